cfg_loader: RTL
===============

// Module: cfg_loader
// PURPOSE
//  Bitstream source for the crossbar programming shift chain: accepts 32-bit config words from a host
//  stream, validates a header and drives prog_o/prog_shft into the first chain element's prog_i/prog_shft.
//  Sits between the host config port and the daisy-chained crossbar/V_/H_ tiles. Asserts fabric_en only
//  after a complete, valid load; the tiles tri-state their config while shifting.
// PARAMETERS
//  CHAIN_LEN  219  total 32-bit words in the daisy chain (sum of all tile l values)
//  CW         $clog2(CHAIN_LEN+1)  word-counter width (localparam, not overridable)
// PORTS
//  clk        in   1   clock
//  nres       in   1   asynchronous active-low reset
//  start      in   1   single-cycle pulse; begins a load when not busy
//  s_data     in   32  host config word
//  s_valid    in   1   s_data valid
//  s_ready    out  1   loader accepts s_data this cycle
//  prog_o     out  32  word to chain prog_i
//  prog_shft  out  1   chain shift enable, one pulse per payload word
//  prog_i     in   32  chain tail (last tile prog_o); used only with CFG_CRC_EN
//  busy       out  1   load in progress (HDR..CHK)
//  fabric_en  out  1   config valid, fabric may run
//  err        out  1   sticky load error, cleared by next start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, sum 0. Reset mid-load abandons it; chain is reset by same nres.
//  States: IDLE -> HDR -> LOAD -> (CHK) -> DONE; any -> ERR on fault.
//  IDLE: s_ready=0. start -> HDR, err<=0, fabric_en<=0, cnt<=0, sum<=0.
//  HDR: s_ready=1. On handshake: s_data[31:16] must be MAGIC 16'hCF60 and s_data[15:0] must equal CHAIN_LEN;
//   else -> ERR. Header word is never shifted into the chain.
//  LOAD: s_ready=1. Handshake (s_valid&s_ready) at cycle n -> prog_o<=s_data, prog_shft=1 at n+1 only;
//   prog_shft=0 in any cycle with no handshake (stalls by host leave the chain static). cnt++ per word.
//   Handshake with cnt==CHAIN_LEN-1 -> CHK (if CFG_CRC_EN) else DONE.
//  prog_o holds last driven word when prog_shft=0; it is 0 only after reset.
//  DONE: s_ready=0, busy=0, fabric_en=1 (one cycle after final prog_shft pulse, so the chain has settled).
//  ERR: s_ready=0, busy=0, err=1, fabric_en=0; stays until start.
//  start while busy: ignored. start in DONE/ERR: restarts (fabric_en drops the next cycle).
//  busy=1 in HDR, LOAD, CHK. s_ready is combinational from state only (never from s_valid).
//  cnt saturates logic: never exceeds CHAIN_LEN-1; no wrap.
// CONFIGURATION
//  CFG_CRC_EN defined: sum <= sum + s_data (mod 2^32) for each payload word; state CHK takes one more
//   handshake word (the trailer, not shifted) which must equal ~sum, else ERR. Also during LOAD, after
//   CHAIN_LEN shifts, prog_i is the first word shifted in; CHK additionally requires prog_i == first payload
//   word (latched at cnt==0), else ERR.
//  CFG_CRC_EN undefined: no CHK state, no trailer, no sum register, prog_i unused.
// STRUCTURE
//  Package cfg_pkg: cfg_state_e enum {IDLE,HDR,LOAD,CHK,DONE,ERR}, CFG_MAGIC=16'hCF60, CFG_WORD_W=32.
//  Sub-module cfg_checksum (accumulator + compare), instantiated only under CFG_CRC_EN.
// TESTING (CHAIN_LEN=4 for bench, chain modelled by 4 crossbar-style shift regs)
//  Valid load, header 32'hCF60_0004, words 1,2,3,4, s_valid constant -> 4 prog_shft pulses, chain holds
//   4,3,2,1 (head..tail), fabric_en=1 one cycle after last pulse, err=0.
//  Bad magic 32'hDEAD_0004 -> ERR next cycle, s_ready=0, no prog_shft ever, err=1 until start.
//  Length 32'hCF60_0005 -> ERR; host bubbles (s_valid low 3 cycles mid-payload) -> prog_shft low during gap,
//   same final chain contents.
//  nres pulse after 2 payload words -> all outputs 0, IDLE; new start + full load succeeds.
//  CFG_CRC_EN: trailer ~(1+2+3+4)=32'hFFFF_FFF5 -> DONE; trailer 32'h0 -> ERR, fabric_en=0.
//  start asserted during LOAD -> ignored, load completes normally.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and constants for the crossbar configuration loader.
// The optional checksum/loop-back check is enabled with the CFG_CRC_EN macro.
package cfg_pkg;

    localparam int          CFG_WORD_W = 32;
    localparam logic [15:0] CFG_MAGIC  = 16'hCF60;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CHK,
        DONE,
        ERR
    } cfg_state_e;

    // A header is accepted only if it carries the magic tag and the exact chain length.
    function automatic logic hdr_valid(input logic [CFG_WORD_W-1:0] word,
                                       input logic [15:0]           len);
        return (word[31:16] == CFG_MAGIC) && (word[15:0] == len);
    endfunction

endpackage

// File: rtl/cfg_checksum.sv
// Payload checksum accumulator and trailer/loop-back comparison for cfg_loader.
// Only instantiated when the CFG_CRC_EN macro is defined.
module cfg_checksum
    import cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  nres,
    input  logic                  clear,
    input  logic                  acc_en,
    input  logic                  first_en,
    input  logic [CFG_WORD_W-1:0] data,
    input  logic [CFG_WORD_W-1:0] prog_i,
    output logic                  trailer_ok,
    output logic                  tail_ok
);

    logic [CFG_WORD_W-1:0] sum;
    logic [CFG_WORD_W-1:0] first;

    // Running mod-2^32 sum of payload words and capture of the first word shifted in.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            sum   <= '0;
            first <= '0;
        end else if (clear) begin
            sum   <= '0;
            first <= '0;
        end else begin
            if (acc_en)   sum   <= sum + data;
            if (first_en) first <= data;
        end
    end

    // Trailer must be the complement of the sum; the chain tail must return the first word.
    assign trailer_ok = (data == ~sum);
    assign tail_ok    = (prog_i == first);

endmodule

// File: rtl/cfg_loader.sv
// Bitstream source for the crossbar programming shift chain.
// Validates a header, shifts CHAIN_LEN payload words into the chain and then enables the fabric.
// Optional feature: define CFG_CRC_EN for a checksum trailer and chain loop-back check.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 219
) (
    input  logic                  clk,
    input  logic                  nres,
    input  logic                  start,
    input  logic [CFG_WORD_W-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [CFG_WORD_W-1:0] prog_o,
    output logic                  prog_shft,
    input  logic [CFG_WORD_W-1:0] prog_i,
    output logic                  busy,
    output logic                  fabric_en,
    output logic                  err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    cfg_state_e    state;
    cfg_state_e    state_next;
    logic [CW-1:0] cnt;
    logic          hs;
    logic          load_hs;
    logic          last_word;
    logic          restart;
    logic          trailer_ok;
    logic          tail_ok;

    assign hs        = s_valid && s_ready;
    assign load_hs   = hs && (state == LOAD);
    assign last_word = (cnt == CW'(CHAIN_LEN - 1));
    // A start is honoured only outside a load in progress.
    assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));

`ifdef CFG_CRC_EN
    cfg_checksum u_checksum (
        .clk        (clk),
        .nres       (nres),
        .clear      (restart),
        .acc_en     (load_hs),
        .first_en   (load_hs && (cnt == '0)),
        .data       (s_data),
        .prog_i     (prog_i),
        .trailer_ok (trailer_ok),
        .tail_ok    (tail_ok)
    );
`else
    // Without the check feature the chain tail is not observed.
    logic unused_prog_i;
    assign unused_prog_i = ^prog_i;
    assign trailer_ok    = 1'b1;
    assign tail_ok       = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = HDR;
            HDR:  if (hs) state_next = hdr_valid(s_data, 16'(CHAIN_LEN)) ? LOAD : ERR;
`ifdef CFG_CRC_EN
            LOAD: if (hs && last_word) state_next = CHK;
            CHK:  if (hs) state_next = trailer_ok ? DONE : ERR;
`else
            LOAD: if (hs && last_word) state_next = DONE;
            CHK:  state_next = ERR;
`endif
            // The chain is static in DONE, so its tail is compared here rather than
            // while the final shift is still in flight.
            DONE: begin
                if (start)         state_next = HDR;
                else if (!tail_ok) state_next = ERR;
            end
            ERR:  if (start) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    // Host handshake and busy flag decode from state only.
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state)
            HDR, LOAD, CHK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // Word counter, chain drive and status registers.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            cnt       <= '0;
            prog_o    <= '0;
            prog_shft <= 1'b0;
            fabric_en <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (restart)                   cnt <= '0;
            else if (load_hs && !last_word) cnt <= cnt + CW'(1);
            prog_shft <= load_hs;
            if (load_hs) prog_o <= s_data;
            // Registered from DONE so the enable trails the final shift by a cycle.
            fabric_en <= (state == DONE) && !start && tail_ok;
            err       <= (state_next == ERR);
        end
    end

endmodule
